seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Parametrised successor of the single-digit hex decoder: holds an N-nibble value in a shadow register and scans the digits one at a time from a prescaled refresh counter.
- Adds leading-zero blanking, a global enable and a dead cycle between digits to prevent ghosting.
- Sits between the arithmetic/operations datapath and the board's segment and anode pins.

---
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit 7-segment display.
// Holds an N-nibble value in a shadow register and scans one digit per
// REFRESH_DIV-cycle slot, with a dead cycle at the end of every slot,
// optional leading-zero blanking and a global enable.
// Optional decimal-point support is compiled in with `define SEG7_SCAN_DP_EN.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an
`ifdef SEG7_SCAN_DP_EN
    ,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic                  dp
`endif
);

    localparam int unsigned VAL_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}}
                                                            : {N_DIGITS{1'b0}};

    logic [VAL_W-1:0]    shadow_q, shadow_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [6:0]          seg_q,    seg_d;
    logic [N_DIGITS-1:0] an_q,     an_d;

    logic                slot_end_c;
    logic [N_DIGITS-1:0] upper_zero_c;
    logic [3:0]          cur_nib_c;
    logic                cur_blank_c;
    logic [6:0]          seg_lit_n_c;
    logic [N_DIGITS-1:0] an_onehot_c;

`ifdef SEG7_SCAN_DP_EN
    logic [N_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
    logic                dp_q,        dp_d;
    logic                cur_dp_c;
`endif

    // Hex nibble to segment pattern, active-low form, bits {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

    // Per-digit flag: this nibble and every more-significant nibble is zero.
    always_comb begin
        logic all_zero;
        all_zero     = 1'b1;
        upper_zero_c = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero        = all_zero & (shadow_q[4*k +: 4] == 4'h0);
            upper_zero_c[k] = all_zero;
        end
    end

    // Select the nibble, blanking flag and decimal point of the scanned digit.
    always_comb begin
        cur_nib_c   = 4'h0;
        cur_blank_c = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        cur_dp_c    = 1'b0;
`endif
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_c   = shadow_q[4*k +: 4];
                cur_blank_c = (k > 0) && upper_zero_c[k];
`ifdef SEG7_SCAN_DP_EN
                cur_dp_c    = dp_shadow_q[k];
`endif
            end
        end
    end

    // Next-state logic: shadow capture, prescaler, digit index and outputs.
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = value;
        end

        slot_end_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));

        cnt_d = slot_end_c ? '0 : cnt_q + CNT_W'(1);

        idx_d = idx_q;
        if (slot_end_c) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        an_onehot_c = N_DIGITS'(1) << idx_q;
        seg_lit_n_c = (lz_blank && cur_blank_c) ? 7'h7F : hex_to_seg_n(cur_nib_c);

        // Dead cycle or disabled: everything dark; otherwise drive the digit.
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (enable && !slot_end_c) begin
            an_d  = AN_ACTIVE_LOW ? ~an_onehot_c : an_onehot_c;
            seg_d = SEG_ACTIVE_LOW ? seg_lit_n_c : ~seg_lit_n_c;
        end

`ifdef SEG7_SCAN_DP_EN
        dp_shadow_d = dp_shadow_q;
        if (load) begin
            dp_shadow_d = dp_in;
        end

        dp_d = SEG_ACTIVE_LOW;
        if (enable && !slot_end_c && cur_dp_c) begin
            dp_d = !SEG_ACTIVE_LOW;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
`ifdef SEG7_SCAN_DP_EN
            dp_shadow_q <= '0;
            dp_q        <= SEG_ACTIVE_LOW;
`endif
        end else begin
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
`ifdef SEG7_SCAN_DP_EN
            dp_shadow_q <= dp_shadow_d;
            dp_q        <= dp_d;
`endif
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
`ifdef SEG7_SCAN_DP_EN
    assign dp  = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver (N_DIGITS=4, REFRESH_DIV=4,
// active-low segments and anodes). Set SEG7_SCAN_DP_EN to include dp checks.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        lz_blank;
    logic        enable;
    logic [6:0]  seg;
    logic [3:0]  an;
`ifdef SEG7_SCAN_DP_EN
    logic [3:0]  dp_in;
    logic        dp;
`endif

    int n_checks = 0;
    int n_errors = 0;
    // Edges since the last reset edge; the next edge sees cnt=t%4, idx=(t/4)%4.
    int t = 0;

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .lz_blank (lz_blank),
        .enable   (enable),
        .seg      (seg),
        .an       (an)
`ifdef SEG7_SCAN_DP_EN
        ,
        .dp_in    (dp_in),
        .dp       (dp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Advance until the next edge will see phase (idx i, cnt c).
    task automatic goto_phase(input int i, input int c);
        int guard;
        guard = 0;
        while ((t % 16) != (i * 4 + c) && guard < 20) begin
            step();
            guard++;
        end
        if ((t % 16) != (i * 4 + c)) begin
            n_checks++;
            n_errors++;
            $display("FAIL goto_phase got=%0d exp=%0d", t % 16, i * 4 + c);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        load     = 1'b1;
        value    = 16'hFFFF;
        enable   = 1'b1;
        lz_blank = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        dp_in    = 4'hF;
`endif
        step();
        step();
        t = 0;
        n_checks++;
        if (an !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_an got=%b exp=%b", an, 4'b1111);
        end
        n_checks++;
        if (seg !== 7'h7F) begin
            n_errors++;
            $display("FAIL reset_seg got=%b exp=%b", seg, 7'h7F);
        end
`ifdef SEG7_SCAN_DP_EN
        n_checks++;
        if (dp !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_dp got=%b exp=%b", dp, 1'b1);
        end
        dp_in = 4'h0;
`endif
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        // Release edge loads 12AF but outputs still decode the reset shadow (0).
        rst   = 1'b0;
        load  = 1'b1;
        value = 16'h12AF;
        step();
        load  = 1'b0;
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001) begin
            n_errors++;
            $display("FAIL scan_first an=%b seg=%b exp an=1110 seg=0000001", an, seg);
        end
        for (int p = 1; p <= 16; p++) begin
            step();
            if ((p % 4) == 3) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end else begin
                case ((p / 4) % 4)
                    0:       begin exp_an = 4'b1110; exp_seg = 7'b0111000; end
                    1:       begin exp_an = 4'b1101; exp_seg = 7'b0001000; end
                    2:       begin exp_an = 4'b1011; exp_seg = 7'b0010010; end
                    default: begin exp_an = 4'b0111; exp_seg = 7'b1001111; end
                endcase
            end
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_errors++;
                $display("FAIL scan p=%0d an=%b seg=%b exp an=%b seg=%b",
                         p, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_enable();
        goto_phase(1, 1);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (an !== 4'b1111 || seg !== 7'h7F) begin
                n_errors++;
                $display("FAIL enable_off k=%0d an=%b seg=%b exp an=1111 seg=1111111", k, an, seg);
            end
        end
        // Ten disabled cycles from (1,1) leave the counters at (3,3): a dead cycle.
        enable = 1'b1;
        step();
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'h7F) begin
            n_errors++;
            $display("FAIL enable_resume_dead an=%b seg=%b exp an=1111 seg=1111111", an, seg);
        end
        step();
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'b0111000) begin
            n_errors++;
            $display("FAIL enable_resume_d0 an=%b seg=%b exp an=1110 seg=0111000", an, seg);
        end
    endtask

    task automatic test_no_load();
        logic [6:0] pat [4];
        pat[0] = 7'b0111000;
        pat[1] = 7'b0001000;
        pat[2] = 7'b0010010;
        pat[3] = 7'b1001111;
        value = 16'h9999;
        for (int d = 0; d < 4; d++) begin
            goto_phase(d, 0);
            step();
            n_checks++;
            if (seg !== pat[d]) begin
                n_errors++;
                $display("FAIL no_load d=%0d seg=%b exp=%b", d, seg, pat[d]);
            end
        end
    endtask

    task automatic test_load_mid();
        goto_phase(2, 0);
        step();
        n_checks++;
        if (an !== 4'b1011 || seg !== 7'b0010010) begin
            n_errors++;
            $display("FAIL load_mid_before an=%b seg=%b exp an=1011 seg=0010010", an, seg);
        end
        value = 16'h17AF;
        load  = 1'b1;
        step();
        load  = 1'b0;
        n_checks++;
        if (an !== 4'b1011 || seg !== 7'b0010010) begin
            n_errors++;
            $display("FAIL load_mid_edge an=%b seg=%b exp an=1011 seg=0010010", an, seg);
        end
        step();
        n_checks++;
        if (an !== 4'b1011 || seg !== 7'b0001111) begin
            n_errors++;
            $display("FAIL load_mid_after an=%b seg=%b exp an=1011 seg=0001111", an, seg);
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] pat5   [4];
        logic [6:0] pat105 [4];
        logic [3:0] exp_an;
        pat5[0]   = 7'b0100100;
        pat5[1]   = 7'h7F;
        pat5[2]   = 7'h7F;
        pat5[3]   = 7'h7F;
        pat105[0] = 7'b0100100;
        pat105[1] = 7'b0000001;
        pat105[2] = 7'b1001111;
        pat105[3] = 7'h7F;
        lz_blank = 1'b1;
        value    = 16'h0005;
        load     = 1'b1;
        step();
        load     = 1'b0;
        for (int d = 0; d < 4; d++) begin
            goto_phase(d, 0);
            step();
            exp_an = ~(4'b0001 << d);
            n_checks++;
            if (an !== exp_an || seg !== pat5[d]) begin
                n_errors++;
                $display("FAIL lz_0005 d=%0d an=%b seg=%b exp an=%b seg=%b",
                         d, an, seg, exp_an, pat5[d]);
            end
        end
        value = 16'h0000;
        load  = 1'b1;
        step();
        load  = 1'b0;
        goto_phase(0, 0);
        step();
        n_checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001) begin
            n_errors++;
            $display("FAIL lz_0000_d0 an=%b seg=%b exp an=1110 seg=0000001", an, seg);
        end
        goto_phase(1, 0);
        step();
        n_checks++;
        if (an !== 4'b1101 || seg !== 7'h7F) begin
            n_errors++;
            $display("FAIL lz_0000_d1 an=%b seg=%b exp an=1101 seg=1111111", an, seg);
        end
        value = 16'h0105;
        load  = 1'b1;
        step();
        load  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            goto_phase(d, 0);
            step();
            n_checks++;
            if (seg !== pat105[d]) begin
                n_errors++;
                $display("FAIL lz_0105 d=%0d seg=%b exp=%b", d, seg, pat105[d]);
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        goto_phase(3, 1);
        step();
        n_checks++;
        if (an !== 4'b0111) begin
            n_errors++;
            $display("FAIL reset_mid_before an=%b exp=0111", an);
        end
        rst   = 1'b1;
        load  = 1'b1;
        value = 16'h3333;
        step();
        t = 0;
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'h7F) begin
            n_errors++;
            $display("FAIL reset_mid_edge an=%b seg=%b exp an=1111 seg=1111111", an, seg);
        end
        rst  = 1'b0;
        load = 1'b0;
        for (int p = 0; p < 4; p++) begin
            step();
            n_checks++;
            if (p == 3) begin
                if (an !== 4'b1111 || seg !== 7'h7F) begin
                    n_errors++;
                    $display("FAIL reset_mid_dead an=%b seg=%b exp an=1111 seg=1111111", an, seg);
                end
            end else begin
                if (an !== 4'b1110 || seg !== 7'b0000001) begin
                    n_errors++;
                    $display("FAIL reset_mid_d0 p=%0d an=%b seg=%b exp an=1110 seg=0000001",
                             p, an, seg);
                end
            end
        end
    endtask

`ifdef SEG7_SCAN_DP_EN
    task automatic test_dp();
        logic exp_dp;
        value = 16'h12AF;
        dp_in = 4'b0100;
        load  = 1'b1;
        step();
        load  = 1'b0;
        dp_in = 4'b0000;
        goto_phase(0, 0);
        for (int p = 0; p < 16; p++) begin
            step();
            exp_dp = ((p % 4) != 3 && (p / 4) == 2) ? 1'b0 : 1'b1;
            n_checks++;
            if (dp !== exp_dp) begin
                n_errors++;
                $display("FAIL dp p=%0d an=%b got=%b exp=%b", p, an, dp, exp_dp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_enable();
        test_no_load();
        test_load_mid();
        test_lz_blank();
        test_reset_mid();
`ifdef SEG7_SCAN_DP_EN
        test_dp();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
